// File: rtl/pe_skew_feeder_if.sv
// Bundle between the activation feeder and its neighbours: the upstream vector
// handshake, the flush control, and the left-edge row enables/data of the PE array.
interface pe_skew_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ROWS       = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [ROWS*DATA_WIDTH-1:0] in_data;
   logic                       in_last;
   logic                       flush;
   logic [ROWS-1:0]            row_en;
   logic [ROWS*DATA_WIDTH-1:0] row_data;
   logic                       busy;
   logic                       done;

   // Producer / observer side (upstream logic and array edge).
   modport master (
      output in_valid, in_data, in_last, flush,
      input  in_ready, row_en, row_data, busy, done
   );

   // Feeder side.
   modport slave (
      input  in_valid, in_data, in_last, flush,
      output in_ready, row_en, row_data, busy, done
   );
endinterface

// File: rtl/pe_skew_feeder.sv
// Left-edge feeder for the systolic PE array. Activation vectors are queued in a
// small registered FIFO, popped one per cycle, and row r is delayed by r cycles to
// form the diagonal wavefront. A tile ends with the vector flagged in_last; done
// pulses in the cycle that vector is presented on row ROWS-1.
module pe_skew_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int ROWS       = 4,
   parameter int DEPTH      = 4
) (
   input logic            FD_clk,
   input logic            FD_rst,
   pe_skew_feeder_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DRN_W = $clog2(ROWS);
   localparam int VEC_W = ROWS * DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   logic [VEC_W-1:0] mem_r [0:DEPTH-1];
   logic [DEPTH-1:0] last_mem_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   state_t           state_r;
   logic [DRN_W-1:0] drain_cnt_r;
   logic             done_r;
   logic             busy_r;

   logic             clr_s;
   logic             full_s;
   logic             empty_s;
   logic             in_ready_s;
   logic             push_s;
   logic             pop_s;
   logic [VEC_W-1:0] pop_data_s;
   logic             pop_last_s;
   logic [ROWS-1:0]  row_en_s;
   logic [VEC_W-1:0] row_data_s;

   // Reset outranks flush for in_ready only; both clear all state identically.
   assign clr_s      = FD_rst || bus.flush;
   assign full_s     = (count_r == CNT_W'(DEPTH));
   assign empty_s    = (count_r == {CNT_W{1'b0}});
   assign in_ready_s = !full_s && !FD_rst;
   // A push offered alongside flush is discarded.
   assign push_s     = bus.in_valid && in_ready_s && !bus.flush;
   assign pop_data_s = mem_r[rd_ptr_r];
   assign pop_last_s = last_mem_r[rd_ptr_r];

   // Pop whenever the FSM may stream and a vector is queued (IDLE pops with no dead cycle).
   always_comb begin
      pop_s = 1'b0;
      if ((state_r == ST_IDLE || state_r == ST_STREAM) && !empty_s) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // FIFO storage: vector and its tile-last flag written at the write pointer.
   always_ff @(posedge FD_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r]      <= bus.in_data;
         last_mem_r[wr_ptr_r] <= bus.in_last;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge FD_clk) begin
      if (clr_s) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Tile FSM with registered busy (next-state decode) and a one-cycle done pulse
   // timed to land on the cycle the last vector reaches row ROWS-1.
   always_ff @(posedge FD_clk) begin
      if (clr_s) begin
         state_r     <= ST_IDLE;
         drain_cnt_r <= {DRN_W{1'b0}};
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!empty_s) begin
                  busy_r <= 1'b1;
                  if (pop_last_s) begin
                     state_r     <= ST_DRAIN;
                     drain_cnt_r <= DRN_W'(ROWS - 1);
                  end else begin
                     state_r <= ST_STREAM;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_STREAM: begin
               busy_r <= 1'b1;
               if (!empty_s && pop_last_s) begin
                  state_r     <= ST_DRAIN;
                  drain_cnt_r <= DRN_W'(ROWS - 1);
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_r == {DRN_W{1'b0}}) begin
                  // A queued next tile resumes streaming straight away.
                  if (empty_s) begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= ST_STREAM;
                     busy_r  <= 1'b1;
                  end
               end else begin
                  drain_cnt_r <= drain_cnt_r - DRN_W'(1);
                  done_r      <= (drain_cnt_r == DRN_W'(1));
                  busy_r      <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               drain_cnt_r <= {DRN_W{1'b0}};
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_WIDTH-1:0] dly_data_r [0:r];
      logic [r:0]            dly_en_r;

      // Row r delay line: stage 0 captures the pop, r more stages add the skew;
      // data only advances behind a valid enable so idle rows hold their last value.
      always_ff @(posedge FD_clk) begin
         if (clr_s) begin
            dly_en_r <= '0;
            for (int k = 0; k <= r; k++) dly_data_r[k] <= {DATA_WIDTH{1'b0}};
         end else begin
            dly_en_r[0] <= pop_s;
            if (pop_s) dly_data_r[0] <= pop_data_s[r*DATA_WIDTH +: DATA_WIDTH];
            for (int k = 1; k <= r; k++) begin
               dly_en_r[k] <= dly_en_r[k-1];
               if (dly_en_r[k-1]) dly_data_r[k] <= dly_data_r[k-1];
            end
         end
      end

      assign row_en_s[r]                               = dly_en_r[r];
      assign row_data_s[r*DATA_WIDTH +: DATA_WIDTH]    = dly_data_r[r];
   end

   assign bus.in_ready = in_ready_s;
   assign bus.row_en   = row_en_s;
   assign bus.row_data = row_data_s;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
endmodule

// File: tb/tb_pe_skew_feeder.sv
// Directed bench for pe_skew_feeder (DATA_WIDTH=32, ROWS=4, DEPTH=4).
// Cycle t = interval after posedge t; inputs are driven and outputs sampled 1ns after the edge.
module tb_pe_skew_feeder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec  = 0;
   int   n_miss = 0;

   pe_skew_feeder_if #(.DATA_WIDTH(32), .ROWS(4)) bus ();

   pe_skew_feeder #(.DATA_WIDTH(32), .ROWS(4), .DEPTH(4)) dut (
      .FD_clk (clk),
      .FD_rst (rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [127:0] d, input logic l);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_last  = l;
   endtask

   function automatic logic [127:0] vec(input logic [31:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   initial begin
      bus.flush = 1'b0;
      drive(1'b0, 128'd0, 1'b0);

      // ---- reset state ----
      tick();
      tick();
      chk("rst_ready", bus.in_ready, 1'b0);
      chk("rst_en",    bus.row_en,   4'd0);
      chk("rst_data",  bus.row_data, 128'd0);
      chk("rst_done",  bus.done,     1'b0);
      chk("rst_busy",  bus.busy,     1'b0);
      rst = 1'b0;
      tick();
      chk("rel_ready", bus.in_ready, 1'b1);

      // ---- single tile of three vectors ----
      drive(1'b1, vec(32'd1, 32'd2, 32'd3, 32'd4), 1'b0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1)      drive(1'b1, vec(32'd5, 32'd6, 32'd7, 32'd8), 1'b0);
         else if (c == 2) drive(1'b1, vec(32'd9, 32'd10, 32'd11, 32'd12), 1'b1);
         else if (c == 3) drive(1'b0, 128'd0, 1'b0);
         chk("t1_en0", bus.row_en[0], (c >= 2 && c <= 4));
         if (c >= 2 && c <= 4) chk("t1_d0", bus.row_data[31:0], 32'(4*(c-2) + 1));
         chk("t1_en3", bus.row_en[3], (c >= 5 && c <= 7));
         if (c >= 5 && c <= 7) chk("t1_d3", bus.row_data[127:96], 32'(4*(c-5) + 4));
         chk("t1_done", bus.done, (c == 7));
         chk("t1_busy", bus.busy, (c >= 2 && c <= 7));
      end
      tick();

      // ---- bubble, with extreme values and hold-on-idle ----
      drive(1'b1, vec(32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF), 1'b0);
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1)      drive(1'b0, 128'd0, 1'b0);
         else if (c == 3) drive(1'b1, vec(32'd11, 32'd22, 32'd33, 32'd44), 1'b1);
         else if (c == 4) drive(1'b0, 128'd0, 1'b0);
         chk("t2_en0", bus.row_en[0], (c == 2 || c == 5));
         if (c >= 2) chk("t2_d0", bus.row_data[31:0], (c < 5) ? 32'h80000000 : 32'd11);
         if (c == 3) chk("t2_d1", bus.row_data[63:32], 32'hFFFFFFFF);
         if (c == 4) chk("t2_d2", bus.row_data[95:64], 32'h7FFFFFFF);
         if (c == 7) chk("t2_d2b", bus.row_data[95:64], 32'd33);
         chk("t2_en3", bus.row_en[3], (c == 5 || c == 8));
         if (c >= 5) chk("t2_d3", bus.row_data[127:96], (c < 8) ? 32'hFFFFFFFF : 32'd44);
         chk("t2_done", bus.done, (c == 8));
      end
      tick();

      // ---- backpressure: fill the FIFO while a 1-vector tile drains ----
      drive(1'b1, vec(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1'b1);
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (c >= 1 && c <= 4) drive(1'b1, vec(32'hB0 + 32'(c-1), 32'd1, 32'd2, 32'd3), 1'b0);
         else if (c == 5)      drive(1'b1, vec(32'hB4, 32'd1, 32'd2, 32'd3), 1'b1);
         else if (c == 8)      drive(1'b0, 128'd0, 1'b0);
         if (c == 1) chk("t3_busy_idle", bus.busy, 1'b0);
         chk("t3_ready", bus.in_ready, !(c == 5 || c == 6));
         chk("t3_done",  bus.done, (c == 5 || c == 14));
         chk("t3_en0",   bus.row_en[0], (c == 2 || (c >= 7 && c <= 11)));
         if (c == 2)            chk("t3_dA", bus.row_data[31:0], 32'hA0);
         if (c >= 7 && c <= 11) chk("t3_dB", bus.row_data[31:0], 32'hB0 + 32'(c-7));
      end
      tick();

      // ---- flush in the second DRAIN cycle with two vectors queued ----
      drive(1'b1, vec(32'hC0, 32'hC1, 32'hC2, 32'hC3), 1'b1);
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1)      drive(1'b1, vec(32'hD0, 32'hD1, 32'hD2, 32'hD3), 1'b0);
         else if (c == 2) drive(1'b1, vec(32'hE0, 32'hE1, 32'hE2, 32'hE3), 1'b0);
         else if (c == 3) begin
            drive(1'b0, 128'd0, 1'b0);
            bus.flush = 1'b1;
         end else if (c == 4) bus.flush = 1'b0;
         if (c == 3) begin
            chk("t4_busy_pre", bus.busy, 1'b1);
            chk("t4_d1_pre",   bus.row_data[63:32], 32'hC1);
         end
         if (c == 4) begin
            chk("t4_data", bus.row_data, 128'd0);
            chk("t4_busy", bus.busy, 1'b0);
            chk("t4_ready", bus.in_ready, 1'b1);
         end
         if (c >= 4) begin
            chk("t4_en",   bus.row_en, 4'd0);
            chk("t4_done", bus.done, 1'b0);
         end
      end

      // ---- reset during STREAM, then a fresh 1-vector tile ----
      drive(1'b1, vec(32'h10, 32'h11, 32'h12, 32'h13), 1'b0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) drive(1'b1, vec(32'h20, 32'h21, 32'h22, 32'h23), 1'b0);
         else if (c == 2) begin
            drive(1'b1, vec(32'h30, 32'h31, 32'h32, 32'h33), 1'b1);
            rst = 1'b1;
            #1;
            chk("t5_ready_rst", bus.in_ready, 1'b0);
         end else if (c == 3) begin
            chk("t5_ready_hold", bus.in_ready, 1'b0);
            chk("t5_en",   bus.row_en, 4'd0);
            chk("t5_data", bus.row_data, 128'd0);
            chk("t5_busy", bus.busy, 1'b0);
            chk("t5_done", bus.done, 1'b0);
         end else if (c == 4) begin
            rst = 1'b0;
            drive(1'b1, vec(32'h40, 32'h41, 32'h42, 32'hFFFFFFFF), 1'b1);
            #1;
            chk("t5_ready_rel", bus.in_ready, 1'b1);
            chk("t5_en_rel",    bus.row_en, 4'd0);
         end else if (c == 5) drive(1'b0, 128'd0, 1'b0);
         if (c == 2) chk("t5_d0_pre", bus.row_data[31:0], 32'h10);
         if (c >= 5) chk("t5_done2", bus.done, (c == 9));
         if (c == 6) chk("t5_d0", bus.row_data[31:0], 32'h40);
         if (c == 9) chk("t5_d3", bus.row_data[127:96], 32'hFFFFFFFF);
         if (c >= 5) chk("t5_en3", bus.row_en[3], (c == 9));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
